// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Arbitrates four requesters for a four-digit segment display. An owner keeps
// the display for at least DWELL_TICKS ticks before another requester may
// preempt it. Every change of ownership passes through a one-cycle GAP state.
// The digit outputs show OFF (16) after a release and DASH (17) after a
// preemption.
// Optional build macro: SEG_ARB_FIXED_PRIO_EN. When it is defined, arbitration
// is fixed priority with the lowest index winning. Only a lower-index
// requester may preempt the owner. When it is undefined (the default),
// arbitration is round-robin.
module seg_display_arbiter #(
    parameter int TICK_DIV    = 100000,
    parameter int DWELL_TICKS = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [95:0] data_in,
    output logic [3:0]  grant,
    output logic [5:0]  num3,
    output logic [5:0]  num2,
    output logic [5:0]  num1,
    output logic [5:0]  num0,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [5:0] CODE_OFF  = 6'd16;
    localparam logic [5:0] CODE_DASH = 6'd17;

    state_t        state, state_next;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [7:0]    dwell, dwell_next;
    logic [1:0]    owner, owner_next;
    logic [3:0]    grant_next;
    logic [23:0]   disp, disp_next;
    logic [23:0]   lane [4];
    logic          win_valid;
    logic [1:0]    win_idx;
    logic          others_pending;
`ifndef SEG_ARB_FIXED_PRIO_EN
    logic [1:0]    last, last_next;
`endif

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign lane[g] = data_in[24*g +: 24];
    end

    assign num3 = disp[23:18];
    assign num2 = disp[17:12];
    assign num1 = disp[11:6];
    assign num0 = disp[5:0];
    assign busy = |grant;
    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    // Any code above DASH is not displayable, so it is shown as DASH.
    function automatic logic [23:0] clamp_codes(input logic [23:0] d);
        logic [23:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (d[6*i +: 6] > CODE_DASH) r[6*i +: 6] = CODE_DASH;
        end
        return r;
    endfunction

    // Free-running tick prescaler that wraps at TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (!rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

`ifdef SEG_ARB_FIXED_PRIO_EN
    // Fixed-priority winner selection: the lowest pending index wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) begin
                win_valid = 1'b1;
                win_idx   = 2'(k);
            end
        end
    end

    // The one-hot grant minus one masks the indices below the owner.
    assign others_pending = |(req & (grant - 4'd1));
`else
    // Round-robin winner selection: search from last+1 upward, modulo 4.
    // The previous owner is therefore considered last.
    always_comb begin
        logic [1:0] idx;
        idx       = 2'd0;
        win_valid = 1'b0;
        win_idx   = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = last + k[1:0];
            if (req[idx]) begin
                win_valid = 1'b1;
                win_idx   = idx;
            end
        end
    end

    assign others_pending = |(req & ~grant);
`endif

    // Next-state logic and the next values of the grant, digit and dwell registers.
    always_comb begin
        state_next = state;
        grant_next = grant;
        disp_next  = disp;
        dwell_next = dwell;
        owner_next = owner;
`ifndef SEG_ARB_FIXED_PRIO_EN
        last_next  = last;
`endif
        case (state)
            IDLE, GAP: begin
                if (win_valid) begin
                    state_next = OWN;
                    grant_next = 4'b0001 << win_idx;
                    owner_next = win_idx;
                    disp_next  = clamp_codes(lane[win_idx]);
                    dwell_next = 8'(DWELL_TICKS);
`ifndef SEG_ARB_FIXED_PRIO_EN
                    last_next  = win_idx;
`endif
                end else begin
                    state_next = IDLE;
                    grant_next = 4'b0000;
                    disp_next  = {4{CODE_OFF}};
                end
            end
            OWN: begin
                if (!req[owner]) begin
                    state_next = GAP;
                    grant_next = 4'b0000;
                    disp_next  = {4{CODE_OFF}};
                end else if ((dwell == 8'd0) && others_pending) begin
                    state_next = GAP;
                    grant_next = 4'b0000;
                    disp_next  = {4{CODE_DASH}};
                end else begin
                    disp_next = clamp_codes(lane[owner]);
                    if (tick && (dwell != 8'd0)) dwell_next = dwell - 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 4'b0000;
                disp_next  = {4{CODE_OFF}};
            end
        endcase
    end

    // State register and the registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= 4'b0000;
            disp  <= {4{CODE_OFF}};
            dwell <= 8'd0;
            owner <= 2'd0;
`ifndef SEG_ARB_FIXED_PRIO_EN
            last  <= 2'd3;
`endif
        end else begin
            state <= state_next;
            grant <= grant_next;
            disp  <= disp_next;
            dwell <= dwell_next;
            owner <= owner_next;
`ifndef SEG_ARB_FIXED_PRIO_EN
            last  <= last_next;
`endif
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter
// Self-checking bench for seg_display_arbiter with TICK_DIV=4 and DWELL_TICKS=2.
// A behavioural reference model works out the expected grant and digit codes
// from the arbitration rules. It advances once per clock edge.
// The bench follows the build macro SEG_ARB_FIXED_PRIO_EN.
module tb_seg_display_arbiter;

    localparam int TDIV  = 4;
    localparam int DWELL = 2;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [95:0] data_in;
    logic [3:0]  grant;
    logic [5:0]  num3, num2, num1, num0;
    logic        busy;

    int tests;
    int failed;

    // Reference model state. m_state values: 0 = idle, 1 = owning, 2 = gap.
    int         m_state;
    int         m_owner;
    int         m_dwell;
    int         m_tick;
    int         m_last;
    logic [3:0] m_grant;
    logic [5:0] m_num [4];

    logic [28:0] obs;
    logic [28:0] exp_v;

    seg_display_arbiter #(.TICK_DIV(TDIV), .DWELL_TICKS(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .grant(grant), .num3(num3), .num2(num2), .num1(num1), .num0(num0),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns the clamped digit code n (3 = num3) of requester i.
    function automatic logic [5:0] fld(input int i, input int n);
        logic [95:0] d;
        logic [5:0]  v;
        d = data_in;
        v = d[24*i + 6*n +: 6];
        return (v > 6'd17) ? 6'd17 : v;
    endfunction

    // Returns the winning requester index, or -1 when nothing is pending.
    function automatic int pick(input logic [3:0] r);
`ifdef SEG_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) if (r[k]) return k;
`else
        for (int k = 1; k <= 4; k++) if (r[(m_last + k) % 4]) return (m_last + k) % 4;
`endif
        return -1;
    endfunction

    // Returns 1 when a requester other than the owner may preempt it.
    function automatic bit can_preempt(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
`ifdef SEG_ARB_FIXED_PRIO_EN
            if (r[k] && k < m_owner) return 1'b1;
`else
            if (r[k] && k != m_owner) return 1'b1;
`endif
        end
        return 1'b0;
    endfunction

    task automatic model_update();
        int w;
        bit t;
        if (!rst_n) begin
            m_state = 0; m_grant = 4'b0; m_last = 3; m_tick = 0; m_dwell = 0;
            for (int n = 0; n < 4; n++) m_num[n] = 6'd16;
        end else begin
            t = (m_tick == TDIV - 1);
            m_tick = (m_tick + 1) % TDIV;
            if (m_state != 1) begin
                w = pick(req);
                if (w >= 0) begin
                    m_state = 1; m_owner = w; m_last = w; m_dwell = DWELL;
                    m_grant = 4'(1 << w);
                    for (int n = 0; n < 4; n++) m_num[n] = fld(w, n);
                end else begin
                    m_state = 0; m_grant = 4'b0;
                    for (int n = 0; n < 4; n++) m_num[n] = 6'd16;
                end
            end else if (!req[m_owner]) begin
                m_state = 2; m_grant = 4'b0;
                for (int n = 0; n < 4; n++) m_num[n] = 6'd16;
            end else if (m_dwell == 0 && can_preempt(req)) begin
                m_state = 2; m_grant = 4'b0;
                for (int n = 0; n < 4; n++) m_num[n] = 6'd17;
            end else begin
                for (int n = 0; n < 4; n++) m_num[n] = fld(m_owner, n);
                if (t && m_dwell > 0) m_dwell--;
            end
        end
        exp_v = {m_grant, m_grant != 4'b0, m_num[3], m_num[2], m_num[1], m_num[0]};
    endtask

    // Advances one clock edge, updates the model and samples the DUT 1 ns later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        obs = {grant, busy, num3, num2, num1, num0};
    endtask

    task automatic set_data(input int i, input int a3, input int a2, input int a1, input int a0);
        data_in[24*i +: 24] = {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req = 4'b1111;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if (obs !== {4'b0, 1'b0, {4{6'd16}}}) begin
                failed++;
                $display("[TB] FAIL reset_state got=%h want=%h", obs, {4'b0, 1'b0, {4{6'd16}}});
            end
        end
        rst_n = 1'b1;
        req = 4'b0;
    endtask

    task automatic test_single_grant();
        set_data(0, 1, 2, 3, 4);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step();
            tests++;
            if (obs !== {4'b0, 1'b0, {4{6'd16}}}) begin
                failed++;
                $display("[TB] FAIL idle_off got=%h want=%h", obs, {4'b0, 1'b0, {4{6'd16}}});
            end
        end
        req = 4'b0001;
        step();
        tests++;
        if (obs !== {4'b0001, 1'b1, 6'd1, 6'd2, 6'd3, 6'd4}) begin
            failed++;
            $display("[TB] FAIL first_grant got=%h want=%h", obs, {4'b0001, 1'b1, 6'd1, 6'd2, 6'd3, 6'd4});
        end
    endtask

    task automatic test_preempt();
        int n;
        set_data(0, 1, 2, 3, 4);
        set_data(2, 9, 8, 7, 6);
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0101;
        n = 0;
        while (n < 30) begin
            step();
            n++;
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("[TB] FAIL preempt_model got=%h want=%h", obs, exp_v);
            end
            if (grant !== 4'b0001) break;
        end
        tests++;
        if (n < 6 || n > 9) begin
            failed++;
            $display("[TB] FAIL preempt_dwell got=%0d cycles want 6..9", n);
        end
        tests++;
        if ({grant, num3, num2, num1, num0} !== {4'b0, {4{6'd17}}}) begin
            failed++;
            $display("[TB] FAIL preempt_gap got=%h want=%h", {grant, num3, num2, num1, num0}, {4'b0, {4{6'd17}}});
        end
        step();
        tests++;
        if ({grant, num3, num2, num1, num0} !== {4'b0100, 6'd9, 6'd8, 6'd7, 6'd6}) begin
            failed++;
            $display("[TB] FAIL preempt_regrant got=%h want=%h", {grant, num3, num2, num1, num0}, {4'b0100, 6'd9, 6'd8, 6'd7, 6'd6});
        end
        req = 4'b0;
    endtask

    task automatic test_release_wins();
        int n;
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0011;
        n = 0;
        while (m_dwell != 0 && n < 30) begin
            step();
            n++;
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("[TB] FAIL release_model got=%h want=%h", obs, exp_v);
            end
        end
        req = 4'b0010;
        step();
        tests++;
        if (obs !== {4'b0, 1'b0, {4{6'd16}}}) begin
            failed++;
            $display("[TB] FAIL release_gap got=%h want=%h", obs, {4'b0, 1'b0, {4{6'd16}}});
        end
        step();
        tests++;
        if (grant !== 4'b0010) begin
            failed++;
            $display("[TB] FAIL release_regrant got=%b want=0010", grant);
        end
        req = 4'b0;
    endtask

`ifndef SEG_ARB_FIXED_PRIO_EN
    task automatic test_round_robin();
        logic [3:0] seq [$];
        logic [3:0] want [5];
        logic [3:0] prev;
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111;
        prev = 4'b0;
        for (int c = 0; c < 200 && seq.size() < 5; c++) begin
            step();
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("[TB] FAIL rr_model got=%h want=%h", obs, exp_v);
            end
            if (prev == 4'b0 && grant != 4'b0) seq.push_back(grant);
            prev = grant;
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (i >= seq.size() || seq[i] !== want[i]) begin
                failed++;
                $display("[TB] FAIL rr_order idx=%0d got=%b want=%b", i, (i < seq.size()) ? seq[i] : 4'bx, want[i]);
            end
        end
        req = 4'b0;
    endtask
`else
    task automatic test_fixed_no_preempt();
        do_reset();
        req = 4'b1001;
        for (int c = 0; c < 40; c++) begin
            step();
            tests++;
            if (grant !== 4'b0001) begin
                failed++;
                $display("[TB] FAIL fixed_hold got=%b want=0001", grant);
            end
        end
        req = 4'b0;
    endtask
`endif

    task automatic test_dash_clamp();
        set_data(0, 5, 40, 17, 18);
        do_reset();
        req = 4'b0001;
        step();
        tests++;
        if ({num3, num2, num1, num0} !== {6'd5, 6'd17, 6'd17, 6'd17}) begin
            failed++;
            $display("[TB] FAIL clamp got=%h want=%h", {num3, num2, num1, num0}, {6'd5, 6'd17, 6'd17, 6'd17});
        end
        set_data(0, 63, 0, 15, 16);
        step();
        tests++;
        if ({num3, num2, num1, num0} !== {6'd17, 6'd0, 6'd15, 6'd16}) begin
            failed++;
            $display("[TB] FAIL clamp_follow got=%h want=%h", {num3, num2, num1, num0}, {6'd17, 6'd0, 6'd15, 6'd16});
        end
        req = 4'b0;
    endtask

    task automatic test_reset_mid_own();
        do_reset();
        req = 4'b0100;
        step();
        step();
        rst_n = 1'b0;
        req = 4'b1010;
        step();
        tests++;
        if (obs !== {4'b0, 1'b0, {4{6'd16}}}) begin
            failed++;
            $display("[TB] FAIL midown_reset got=%h want=%h", obs, {4'b0, 1'b0, {4{6'd16}}});
        end
        rst_n = 1'b1;
        step();
        tests++;
        if (grant !== 4'b0010) begin
            failed++;
            $display("[TB] FAIL post_reset_grant got=%b want=0010", grant);
        end
        req = 4'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++)
                set_data(i, $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 63));
            rst_n = ($urandom_range(0, 99) != 0);
            step();
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("[TB] FAIL random_model cycle=%0d got=%h want=%h", c, obs, exp_v);
            end
        end
        rst_n = 1'b1;
        req = 4'b0;
    endtask

    initial begin
        tests   = 0;
        failed  = 0;
        rst_n   = 1'b0;
        req     = 4'b0;
        data_in = '0;
        test_reset();
        test_single_grant();
        test_preempt();
        test_release_wins();
`ifndef SEG_ARB_FIXED_PRIO_EN
        test_round_robin();
`else
        test_fixed_no_preempt();
`endif
        test_dash_clamp();
        test_reset_mid_own();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
